// File: rtl/mcs4_pkg.sv
// Shared constants and types for the MCS-4 bus sequencer.
package mcs4_pkg;

    // Subcycle indices; also the bit position in the one-hot state output.
    localparam int A1       = 0;
    localparam int A2       = 1;
    localparam int A3       = 2;
    localparam int M1       = 3;
    localparam int M2       = 4;
    localparam int X1       = 5;
    localparam int X2       = 6;
    localparam int X3       = 7;
    localparam int ONEHOT_W = 8;

    localparam logic [3:0] OPR_SRC = 4'h2;
    localparam logic [3:0] OPR_IO  = 4'hE;

    // Locked states share their encoding with the subcycle index so the
    // one-hot decode is a plain shift; UNLOCKED sits outside that range.
    typedef enum logic [3:0] {
        ST_A1       = 4'd0,
        ST_A2       = 4'd1,
        ST_A3       = 4'd2,
        ST_M1       = 4'd3,
        ST_M2       = 4'd4,
        ST_X1       = 4'd5,
        ST_X2       = 4'd6,
        ST_X3       = 4'd7,
        ST_UNLOCKED = 4'd8
    } seq_state_t;

    function automatic logic [ONEHOT_W-1:0] state_onehot(input seq_state_t s);
        if (s == ST_UNLOCKED) begin
            return '0;
        end
        return ONEHOT_W'(1) << s[2:0];
    endfunction

endpackage

// File: rtl/mcs4_bus_seq_if.sv
// CPU-side bus signals observed by the sequencer and the decoded results.
interface mcs4_bus_seq_if;
    import mcs4_pkg::*;

    logic                PHI1_i;
    logic                PHI2_i;
    logic                SYNC_i;
    logic                CM_i;
    logic [3:0]          D_i;
    logic [ONEHOT_W-1:0] state_o;
    logic [11:0]         addr_o;
    logic [3:0]          opr_o;
    logic [3:0]          opa_o;
    logic                rom_drv_o;
    logic                sel_o;
    logic                io_o;
    logic                sync_err_o;

    modport master (
        output PHI1_i, PHI2_i, SYNC_i, CM_i, D_i,
        input  state_o, addr_o, opr_o, opa_o, rom_drv_o, sel_o, io_o, sync_err_o
    );

    modport slave (
        input  PHI1_i, PHI2_i, SYNC_i, CM_i, D_i,
        output state_o, addr_o, opr_o, opa_o, rom_drv_o, sel_o, io_o, sync_err_o
    );
endinterface

// File: rtl/mcs4_phase_det.sv
// PHI2 edge detection and a "PHI1 seen since the last PHI2 fall" flag.
module mcs4_phase_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_phi1,
    input  logic i_phi2,
    output logic o_phi2_rise,
    output logic o_phi2_fall,
    output logic o_phi1_seen
);

    logic r_phi2_prev;
    logic r_phi1_seen;

    // Edge detects act on the clock where the new level is first sampled.
    assign o_phi2_rise = i_phi2 & ~r_phi2_prev;
    assign o_phi2_fall = ~i_phi2 & r_phi2_prev;
    // A PHI1 high on the current clock counts as seen.
    assign o_phi1_seen = r_phi1_seen | i_phi1;

    // PHI2 history and PHI1 flag; a PHI2 fall opens a new PHI1 window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_phi2_prev <= 1'b0;
            r_phi1_seen <= 1'b0;
        end else begin
            r_phi2_prev <= i_phi2;
            if (o_phi2_fall) begin
                r_phi1_seen <= i_phi1;
            end else begin
                r_phi1_seen <= r_phi1_seen | i_phi1;
            end
        end
    end

endmodule

// File: rtl/mcs4_bus_seq.sv
// MCS-4 bus subcycle sequencer: tracks A1..X3, latches address/opcode,
// decodes ROM drive window, SRC chip select and I/O strobe.
module mcs4_bus_seq
    import mcs4_pkg::*;
#(
    parameter logic [3:0] CHIP_ID = 4'h0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mcs4_bus_seq_if.slave  bus
);

    logic w_phi2_rise;
    logic w_phi2_fall;
    logic w_phi1_seen;
    logic w_locked;
    logic w_fault;

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [ONEHOT_W-1:0] r_state_oh;
    logic [11:0]         r_addr;
    logic [3:0]          r_opr;
    logic [3:0]          r_opa;
    logic                r_cm_m2;
    logic                r_sel;
    logic                r_rom_drv;
    logic                r_io;
    logic                r_sync_err;

    mcs4_phase_det u_phase_det (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_phi1      (bus.PHI1_i),
        .i_phi2      (bus.PHI2_i),
        .o_phi2_rise (w_phi2_rise),
        .o_phi2_fall (w_phi2_fall),
        .o_phi1_seen (w_phi1_seen)
    );

    assign w_locked = (r_state != ST_UNLOCKED);
    // Missing PHI1 before a PHI2 rise means the phase relationship is lost.
    assign w_fault  = w_phi2_rise & w_locked & ~w_phi1_seen;

    // Next subcycle: PHI1 fault drops lock, otherwise advance on PHI2 fall.
    always_comb begin
        w_state_next = r_state;
        if (w_fault) begin
            w_state_next = ST_UNLOCKED;
        end else if (w_phi2_fall) begin
            if (!w_locked) begin
                if (bus.SYNC_i) begin
                    w_state_next = ST_A1;
                end
            end else if (bus.SYNC_i || r_state == ST_X3) begin
                w_state_next = ST_A1;
            end else begin
                w_state_next = seq_state_t'(r_state + 4'd1);
            end
        end
    end

    // Sequencer state, bus captures and registered decode outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_UNLOCKED;
            r_state_oh <= '0;
            r_addr     <= 12'h000;
            r_opr      <= 4'h0;
            r_opa      <= 4'h0;
            r_cm_m2    <= 1'b0;
            r_sel      <= 1'b0;
            r_rom_drv  <= 1'b0;
            r_io       <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_state_oh <= state_onehot(w_state_next);
            r_rom_drv  <= ((w_state_next == ST_M1) || (w_state_next == ST_M2)) &&
                          (r_addr[11:10] == CHIP_ID[3:2]);
            r_io       <= w_phi2_fall && (r_state == ST_M2) && (r_opr == OPR_IO) &&
                          r_cm_m2 && r_sel;
            r_sync_err <= w_fault ||
                          (w_phi2_fall && bus.SYNC_i && w_locked && (r_state != ST_X3));
            if (w_phi2_rise && !w_fault) begin
                unique case (r_state)
                    ST_A1:   r_addr[3:0]  <= bus.D_i;
                    ST_A2:   r_addr[7:4]  <= bus.D_i;
                    ST_A3:   r_addr[11:8] <= bus.D_i;
                    ST_M1:   r_opr        <= bus.D_i;
                    ST_M2: begin
                        r_opa   <= bus.D_i;
                        r_cm_m2 <= bus.CM_i;
                    end
                    ST_X2: begin
                        if ((r_opr == OPR_SRC) && r_opa[0]) begin
                            r_sel <= (bus.D_i == CHIP_ID);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.state_o    = r_state_oh;
    assign bus.addr_o     = r_addr;
    assign bus.opr_o      = r_opr;
    assign bus.opa_o      = r_opa;
    assign bus.rom_drv_o  = r_rom_drv;
    assign bus.sel_o      = r_sel;
    assign bus.io_o       = r_io;
    assign bus.sync_err_o = r_sync_err;

endmodule

// File: tb/tb_mcs4_bus_seq.sv
// Self-checking bench for mcs4_bus_seq: directed scenarios then random
// subcycles, compared against an event-level model of the bus protocol.
module tb_mcs4_bus_seq;

    localparam logic [3:0] CHIP = 4'h4;

    logic clk;
    logic rst;

    mcs4_bus_seq_if bus ();

    mcs4_bus_seq #(.CHIP_ID(CHIP)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: subcycle index 0..7 (A1..X3), -1 when unlocked.
    int         m_state;
    logic [11:0] m_addr;
    logic [3:0]  m_opr;
    logic [3:0]  m_opa;
    logic        m_sel;
    logic        m_cm;
    int          exp_io;
    int          exp_err;
    int          io_cnt;
    int          err_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.io_o === 1'b1)       io_cnt++;
        if (bus.sync_err_o === 1'b1) err_cnt++;
    endtask

    task automatic model_reset();
        m_state = -1;
        m_addr  = 12'h000;
        m_opr   = 4'h0;
        m_opa   = 4'h0;
        m_sel   = 1'b0;
        m_cm    = 1'b0;
    endtask

    function automatic logic [7:0] exp_onehot();
        if (m_state < 0) return 8'h00;
        return 8'(1 << m_state);
    endfunction

    function automatic logic exp_rom();
        return ((m_state == 3) || (m_state == 4)) && (m_addr[11:10] == CHIP[3:2]);
    endfunction

    task automatic check_outputs(input string where);
        chk({where, ".state"}, 32'(bus.state_o), 32'(exp_onehot()));
        chk({where, ".addr"},  32'(bus.addr_o),  32'(m_addr));
        chk({where, ".opr"},   32'(bus.opr_o),   32'(m_opr));
        chk({where, ".opa"},   32'(bus.opa_o),   32'(m_opa));
        chk({where, ".sel"},   32'(bus.sel_o),   32'(m_sel));
        chk({where, ".rom"},   32'(bus.rom_drv_o), 32'(exp_rom()));
    endtask

    // One bus subcycle: PHI1 pulse, PHI2 pulse; D/CM valid across PHI2,
    // SYNC valid at the PHI2 fall.
    task automatic subcycle(input logic sync, input logic [3:0] d, input logic cm,
                            input logic phi1_en, input string where);
        int prev;
        prev    = m_state;
        exp_io  = 0;
        exp_err = 0;
        io_cnt  = 0;
        err_cnt = 0;
        bus.PHI1_i = phi1_en;
        bus.SYNC_i = sync;
        bus.D_i    = d;
        bus.CM_i   = cm;
        tick();
        tick();
        bus.PHI1_i = 1'b0;
        tick();
        bus.PHI2_i = 1'b1;
        tick();
        // PHI2 rise event
        if (m_state >= 0 && !phi1_en) begin
            m_state = -1;
            exp_err++;
        end else if (m_state >= 0) begin
            case (m_state)
                0: m_addr[3:0]  = d;
                1: m_addr[7:4]  = d;
                2: m_addr[11:8] = d;
                3: m_opr = d;
                4: begin m_opa = d; m_cm = cm; end
                6: if (m_opr == 4'h2 && m_opa[0]) m_sel = (d == CHIP);
                default: ;
            endcase
        end
        tick();
        bus.PHI2_i = 1'b0;
        tick();
        // PHI2 fall event
        if (m_state < 0) begin
            if (sync) m_state = 0;
        end else begin
            if (m_state == 4 && m_opr == 4'hE && m_cm && m_sel) exp_io++;
            if (sync && m_state != 7) exp_err++;
            m_state = sync ? 0 : (m_state + 1) % 8;
        end
        bus.SYNC_i = 1'b0;
        check_outputs(where);
        chk({where, ".io_pulses"},  32'(io_cnt),  32'(exp_io));
        chk({where, ".err_pulses"}, 32'(err_cnt), 32'(exp_err));
        $display("sub %-8s from=%0d sync=%0b d=%h cm=%0b phi1=%0b -> state=%02h addr=%03h opr=%h opa=%h sel=%0b rom=%0b io=%0d err=%0d",
                 where, prev, sync, d, cm, phi1_en, bus.state_o, bus.addr_o,
                 bus.opr_o, bus.opa_o, bus.sel_o, bus.rom_drv_o, io_cnt, err_cnt);
    endtask

    // One full instruction cycle starting from A1, SYNC given in X3.
    task automatic instr(input logic [11:0] a, input logic [3:0] opr, input logic [3:0] opa,
                         input logic cm, input logic [3:0] x2d, input string where);
        subcycle(1'b0, a[3:0],  1'b0, 1'b1, {where, "_A1"});
        subcycle(1'b0, a[7:4],  1'b0, 1'b1, {where, "_A2"});
        subcycle(1'b0, a[11:8], 1'b0, 1'b1, {where, "_A3"});
        subcycle(1'b0, opr,     1'b0, 1'b1, {where, "_M1"});
        subcycle(1'b0, opa,     cm,   1'b1, {where, "_M2"});
        subcycle(1'b0, 4'h0,    1'b0, 1'b1, {where, "_X1"});
        subcycle(1'b0, x2d,     1'b0, 1'b1, {where, "_X2"});
        subcycle(1'b1, 4'h0,    1'b0, 1'b1, {where, "_X3"});
    endtask

    initial begin
        logic       sync;
        logic       p1;
        logic [3:0] d;
        bus.PHI1_i = 1'b0;
        bus.PHI2_i = 1'b0;
        bus.SYNC_i = 1'b0;
        bus.CM_i   = 1'b0;
        bus.D_i    = 4'h0;
        rst        = 1'b1;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_outputs("reset");
        chk("reset.io",  32'(bus.io_o),       32'd0);
        chk("reset.err", 32'(bus.sync_err_o), 32'd0);

        // Unlocked: PHI2 pulses without SYNC never lock.
        for (int i = 0; i < 8; i++) subcycle(1'b0, 4'(i), 1'b0, 1'b1, "nosync");

        // Lock, then walk a full cycle fetching 0x123 / A5.
        subcycle(1'b1, 4'h0, 1'b0, 1'b1, "lock");
        instr(12'h123, 4'hA, 4'h5, 1'b0, 4'h0, "walk");

        // SRC to chip 4 from a ROM on this chip, then an I/O op from chip 0.
        instr(12'h456, 4'h2, 4'h1, 1'b0, 4'h4, "src");
        instr(12'h056, 4'hE, 4'h0, 1'b1, 4'h0, "io");

        // SYNC arriving in M1 resynchronises with an error pulse.
        subcycle(1'b0, 4'h7, 1'b0, 1'b1, "rs_A1");
        subcycle(1'b0, 4'h8, 1'b0, 1'b1, "rs_A2");
        subcycle(1'b0, 4'h9, 1'b0, 1'b1, "rs_A3");
        subcycle(1'b1, 4'h3, 1'b0, 1'b1, "rs_M1");

        // Walk to X1, then reset there.
        subcycle(1'b0, 4'h1, 1'b0, 1'b1, "pre_A1");
        subcycle(1'b0, 4'h2, 1'b0, 1'b1, "pre_A2");
        subcycle(1'b0, 4'h3, 1'b0, 1'b1, "pre_A3");
        subcycle(1'b0, 4'h4, 1'b0, 1'b1, "pre_M1");
        subcycle(1'b0, 4'h5, 1'b0, 1'b1, "pre_M2");
        rst = 1'b1;
        tick();
        model_reset();
        check_outputs("midrst");
        chk("midrst.io",  32'(bus.io_o),       32'd0);
        chk("midrst.err", 32'(bus.sync_err_o), 32'd0);
        $display("rst in X1 -> state=%02h addr=%03h", bus.state_o, bus.addr_o);
        rst = 1'b0;
        tick();

        // Missing PHI1 in a locked cycle drops lock.
        subcycle(1'b1, 4'h0, 1'b0, 1'b1, "relock");
        subcycle(1'b0, 4'h0, 1'b0, 1'b1, "f_A1");
        subcycle(1'b0, 4'h0, 1'b0, 1'b0, "f_A2");

        // Random subcycles: SYNC mostly in X3, occasional faults and resyncs.
        for (int i = 0; i < 300; i++) begin
            if (m_state < 0)       sync = ($urandom_range(0, 1) == 0);
            else if (m_state == 7) sync = ($urandom_range(0, 9) != 0);
            else                   sync = ($urandom_range(0, 29) == 0);
            p1 = ($urandom_range(0, 39) != 0);
            d  = 4'($urandom);
            if (m_state == 3 && $urandom_range(0, 1) == 0) d = ($urandom_range(0, 1) == 0) ? 4'h2 : 4'hE;
            if (m_state == 4 && $urandom_range(0, 1) == 0) d = 4'h1;
            if (m_state == 6 && $urandom_range(0, 1) == 0) d = CHIP;
            if (m_state == 2 && $urandom_range(0, 1) == 0) d = {CHIP[3:2], 2'($urandom)};
            subcycle(sync, d, 1'($urandom), p1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
